// File: rtl/delay_extclk.sv
// Board-side clock divider and SPI chip-select delay line on the external oscillator clock.
// Define LOOPBACK_CLK_EN to derive the tick from the board-looped lac1_clk instead of the counter.
`timescale 1ns/1ps
module delay_extclk #(
  parameter int unsigned DIV_LOG2  = 4,
  parameter int unsigned DELAY_LEN = 7
) (
  input  logic ext_clk_in,
  input  logic nreset,
  input  logic lac0_clk,
  input  logic lac1_clk,
  input  logic sclk_in,
  input  logic cs,
  input  logic sdo,
  output logic ref_lac0_out,
  output logic ref_lac1_out,
  output logic lac0_en,
  output logic lac1_en,
  output logic div16_out,
  output logic div16_out_oe,
  output logic miso,
  output logic miso_en,
  output logic sclk_out,
  output logic sclk_out_en,
  output logic cs_out,
  output logic cs_out_en
);

  logic [1:0]          rst_sync_q;
  logic                rst_n_s;
  logic [DIV_LOG2-1:0] cnt_q, cnt_d;
  logic                en_q;
  logic                tick;
  logic                cs_sync_q, cs_sync_d;
  logic                ff1_q, ff1_d;
  logic                ff2_q, ff2_d;
  logic                prev_q, prev_d;
  logic [DELAY_LEN-1:0] shift_q, shift_d;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge ext_clk_in or negedge nreset) begin
    if (!nreset) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_s = rst_sync_q[1];

`ifdef LOOPBACK_CLK_EN
  logic [2:0] lac1_sync_q;
  logic [1:0] lac0_sync_unused_q;

  always_ff @(posedge ext_clk_in or negedge rst_n_s) begin
    if (!rst_n_s) begin
      lac1_sync_q        <= '0;
      lac0_sync_unused_q <= '0;
    end else begin
      lac1_sync_q        <= {lac1_sync_q[1:0], lac1_clk};
      lac0_sync_unused_q <= {lac0_sync_unused_q[0], lac0_clk};
    end
  end
  assign tick = lac1_sync_q[1] & ~lac1_sync_q[2];
`else
  logic lac_unused;
  assign lac_unused = lac0_clk ^ lac1_clk;
  assign tick = (cnt_q == '1);
`endif

  assign cnt_d = cnt_q + 1'b1;

  always_comb begin
    cs_sync_d = cs_sync_q;
    ff1_d     = ff1_q;
    ff2_d     = ff2_q;
    prev_d    = prev_q;
    shift_d   = shift_q;
    if (tick) begin
      cs_sync_d = cs;
      ff1_d     = sclk_in;
      ff2_d     = ff1_q;
      prev_d    = ff2_q;
      // An idle CS refills the line; it wins over a coincident SCLK edge.
      if (cs_sync_q)
        shift_d = '1;
      else if (ff2_q && !prev_q)
        shift_d = {shift_q[DELAY_LEN-2:0], cs_sync_q};
    end
  end

  always_ff @(posedge ext_clk_in or negedge rst_n_s) begin
    if (!rst_n_s) begin
      cnt_q     <= '0;
      en_q      <= 1'b0;
      cs_sync_q <= 1'b0;
      ff1_q     <= 1'b0;
      ff2_q     <= 1'b0;
      prev_q    <= 1'b0;
      shift_q   <= '1;
    end else begin
      cnt_q     <= cnt_d;
      en_q      <= 1'b1;
      cs_sync_q <= cs_sync_d;
      ff1_q     <= ff1_d;
      ff2_q     <= ff2_d;
      prev_q    <= prev_d;
      shift_q   <= shift_d;
    end
  end

  assign ref_lac0_out = cnt_q[0];
  assign ref_lac1_out = cnt_q[DIV_LOG2-1];
  assign div16_out    = cnt_q[DIV_LOG2-1];
  assign lac0_en      = en_q;
  assign lac1_en      = en_q;
  assign div16_out_oe = en_q;
  assign miso_en      = en_q;
  assign sclk_out_en  = en_q;
  assign cs_out_en    = en_q;
  assign miso         = sdo;
  assign sclk_out     = ff2_q;
  assign cs_out       = shift_q[DELAY_LEN-1];

endmodule

// File: tb/tb_delay_extclk.sv
// Self-checking bench for delay_extclk: divider, enables, CS delay line, MISO passthrough.
`timescale 1ns/1ps
module tb_delay_extclk;

  logic clk = 1'b0;
  logic nreset, sclk_in, cs, sdo;
  logic ref_lac0_out, ref_lac1_out, lac0_en, lac1_en, div16_out, div16_out_oe;
  logic miso, miso_en, sclk_out, sclk_out_en, cs_out, cs_out_en;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [6:0] model;
  logic       exp_q[$];
  int         pulse_no = 0;

  typedef struct {
    logic cs;
    logic sdo;
    logic exp_miso;
  } vec_t;
  vec_t vecs[6];

  always #3.125 clk = ~clk;

  delay_extclk #(.DIV_LOG2(4), .DELAY_LEN(7)) dut (
    .ext_clk_in(clk), .nreset(nreset),
    .lac0_clk(ref_lac0_out), .lac1_clk(ref_lac1_out),
    .sclk_in(sclk_in), .cs(cs), .sdo(sdo),
    .ref_lac0_out(ref_lac0_out), .ref_lac1_out(ref_lac1_out),
    .lac0_en(lac0_en), .lac1_en(lac1_en),
    .div16_out(div16_out), .div16_out_oe(div16_out_oe),
    .miso(miso), .miso_en(miso_en),
    .sclk_out(sclk_out), .sclk_out_en(sclk_out_en),
    .cs_out(cs_out), .cs_out_en(cs_out_en)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  function automatic logic all_en();
    return lac0_en & lac1_en & div16_out_oe & miso_en & sclk_out_en & cs_out_en;
  endfunction

  function automatic logic any_en();
    return lac0_en | lac1_en | div16_out_oe | miso_en | sclk_out_en | cs_out_en;
  endfunction

  // Period between two rising edges of a divider output, bounded.
  task automatic measure(input int sel, input int exp, input string name);
    logic p, c;
    int first, period;
    first  = -1;
    period = 0;
    p = (sel == 0) ? ref_lac0_out : ref_lac1_out;
    for (int i = 0; i < 100 && period == 0; i++) begin
      @(negedge clk);
      c = (sel == 0) ? ref_lac0_out : ref_lac1_out;
      if (c && !p) begin
        if (first < 0) first = i;
        else           period = i - first;
      end
      p = c;
    end
    check(name, period, exp);
  endtask

  // One 1 MHz SCLK pulse: expectation queued on drive, compared 5 ticks after the fall.
  task automatic sclk_pulse();
    logic e;
    pulse_no++;
    model = {model[5:0], 1'b0};
    exp_q.push_back(model[6]);
    sclk_in = 1'b1;
    wait_cycles(80);
    sclk_in = 1'b0;
    wait_cycles(80);
    e = exp_q.pop_front();
    check($sformatf("cs_out_pulse%0d", pulse_no), int'(cs_out), int'(e));
  endtask

  initial begin
    vecs[0] = '{cs: 1'b0, sdo: 1'b1, exp_miso: 1'b1};
    vecs[1] = '{cs: 1'b0, sdo: 1'b0, exp_miso: 1'b0};
    vecs[2] = '{cs: 1'b1, sdo: 1'b1, exp_miso: 1'b1};
    vecs[3] = '{cs: 1'b1, sdo: 1'b0, exp_miso: 1'b0};
    vecs[4] = '{cs: 1'b0, sdo: 1'b1, exp_miso: 1'b1};
    vecs[5] = '{cs: 1'b1, sdo: 1'b1, exp_miso: 1'b1};

    nreset = 1'b0; cs = 1'b1; sclk_in = 1'b0; sdo = 1'b0;
    model = 7'h7F;
    wait_cycles(40);
    check("rst_ref_lac0", int'(ref_lac0_out), 0);
    check("rst_ref_lac1", int'(ref_lac1_out), 0);
    check("rst_div16", int'(div16_out), 0);
    check("rst_enables", int'(any_en()), 0);
    check("rst_cs_out", int'(cs_out), 1);
    check("rst_sclk_out", int'(sclk_out), 0);

    nreset = 1'b1;
    wait_cycles(2);
    check("en_during_sync", int'(any_en()), 0);
    wait_cycles(1);
    check("en_after_sync", int'(all_en()), 1);

    wait_cycles(40 * 16);
    check("idle_cs_out", int'(cs_out), 1);
    check("idle_enables", int'(all_en()), 1);
    measure(0, 2, "ref_lac0_period");
    measure(1, 16, "ref_lac1_period");
    check("div16_eq_lac1", int'(div16_out), int'(ref_lac1_out));

    cs = 1'b0;
    wait_cycles(80);
    check("cs_low_no_sclk", int'(cs_out), 1);

    for (int i = 0; i < 12; i++) sclk_pulse();

    cs = 1'b1;
    model = 7'h7F;
    wait_cycles(40);
    check("cs_rise_recover", int'(cs_out), 1);

    cs = 1'b0;
    wait_cycles(80);
    for (int i = 0; i < 4; i++) sclk_pulse();

    nreset = 1'b0;
    #1;
    check("midreset_cs_out", int'(cs_out), 1);
    model = 7'h7F;
    wait_cycles(10);
    nreset = 1'b1;
    wait_cycles(40);
    check("post_reset_cs_out", int'(cs_out), 1);
    for (int i = 0; i < 7; i++) sclk_pulse();

    for (int i = 0; i < 6; i++) begin
      cs  = vecs[i].cs;
      sdo = vecs[i].sdo;
      #1;
      check($sformatf("miso_vec%0d", i), int'(miso), int'(vecs[i].exp_miso));
      wait_cycles(3);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
